// File: rtl/sat_accum.sv
// Saturating frame accumulator: reduces a stream of WIDTH-bit samples to one
// result per frame with unsigned/signed saturation or wrap at every addition.
module sat_accum #(
  parameter int WIDTH = 12,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             ovf
);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  localparam logic [WIDTH-1:0] SAT_UMAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SAT_SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [LEN_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [LEN_W-1:0] r_len;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_ovf_nxt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [1:0]       w_mode_nxt;
  logic [LEN_W-1:0] w_len_nxt;

  logic             w_accept;
  logic             w_first;
  logic [1:0]       w_mode;
  logic [LEN_W-1:0] w_len;
  logic             w_last;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic             w_sovf;
  logic [WIDTH-1:0] w_step_val;
  logic             w_step_flag;

  assign in_ready  = (r_state == ST_ACC) & ~clr & rst_n;
  assign out_valid = (r_state == ST_HOLD);
  assign dout      = r_acc;
  assign ovf       = r_ovf;

  // The first sample of a frame must already see the mode/len being latched.
  assign w_accept = in_valid & in_ready;
  assign w_first  = (r_cnt == '0);
  assign w_mode   = w_first ? mode : r_mode;
  assign w_len    = w_first ? len  : r_len;
  assign w_last   = (w_len == '0) || (r_cnt == w_len - LEN_ONE);

  assign w_sum   = {1'b0, r_acc} + {1'b0, din};
  assign w_carry = w_sum[WIDTH];
  assign w_sovf  = (r_acc[WIDTH-1] == din[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_step_val  = w_sum[WIDTH-1:0];
    w_step_flag = w_carry;
    case (w_mode)
      2'b00: if (w_carry) w_step_val = SAT_UMAX;
      2'b01: begin
        w_step_flag = w_sovf;
        if (w_sovf) w_step_val = r_acc[WIDTH-1] ? SAT_SMIN : SAT_SMAX;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_len_nxt   = r_len;
    if (clr) begin
      w_state_nxt = ST_ACC;
      w_acc_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_ACC: if (w_accept) begin
          w_acc_nxt = w_step_val;
          w_ovf_nxt = r_ovf | w_step_flag;
          if (w_first) begin
            w_mode_nxt = mode;
            w_len_nxt  = len;
          end
          // cnt parks at len-1 on the final sample so it never wraps.
          if (w_last) w_state_nxt = ST_HOLD;
          else        w_cnt_nxt   = r_cnt + LEN_ONE;
        end
        ST_HOLD: if (out_ready) begin
          w_state_nxt = ST_ACC;
          w_acc_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
        default: w_state_nxt = ST_ACC;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ACC;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_len   <= LEN_ONE;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_len   <= w_len_nxt;
    end
  end

endmodule

// File: tb/tb_sat_accum.sv
// Self-checking bench for sat_accum: table-driven frames with a result
// scoreboard, plus hand-written backpressure, clr and reset sequences.
module tb_sat_accum;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [1:0]  mode;
  logic [7:0]  len;
  logic [11:0] din, dout;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]       mode;
    logic [7:0]       len;
    int               n;
    logic [3:0][11:0] s;
    logic [11:0]      exp_d;
    logic             exp_o;
    bit               scramble;
  } vec_t;

  typedef struct packed {
    logic [11:0] d;
    logic        o;
  } exp_t;

  exp_t q[$];
  vec_t vecs[11];

  sat_accum #(.WIDTH(12), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every completed output handshake with the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !clr && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got dout=%h ovf=%b expected none", dout, ovf);
      end else begin
        e = q.pop_front();
        check("result_dout", 32'(dout), 32'(e.d));
        check("result_ovf", 32'(ovf), 32'(e.o));
      end
    end
  end

  function automatic vec_t mk(input logic [1:0] m, input logic [7:0] l, input int n,
                              input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [11:0] d,
                              input logic [11:0] ed, input logic eo, input bit scr);
    vec_t v;
    v.mode = m; v.len = l; v.n = n;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.exp_d = ed; v.exp_o = eo; v.scramble = scr;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the sample is taken.
  task automatic wait_accept();
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic feed(input vec_t v);
    mode = v.mode;
    len  = v.len;
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      din      = v.s[i];
      wait_accept();
      if (i == 0 && v.scramble) begin
        mode = 2'b01;
        len  = 8'd1;
      end
    end
    in_valid = 1'b0;
    check("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic run_frame(input vec_t v);
    q.push_back('{d: v.exp_d, o: v.exp_o});
    feed(v);
    @(posedge clk);
    #1;
    check("back_to_back_in_ready", 32'(in_ready), 32'd1);
    wait_drain();
  endtask

  initial begin
    vecs[0]  = mk(2'b00, 8'd3, 3, 12'h800, 12'h900, 12'h001, 12'h000, 12'hFFF, 1'b1, 1'b0);
    vecs[1]  = mk(2'b01, 8'd2, 2, 12'h7F0, 12'h020, 12'h000, 12'h000, 12'h7FF, 1'b1, 1'b0);
    vecs[2]  = mk(2'b01, 8'd3, 3, 12'h7F0, 12'h020, 12'h800, 12'h000, 12'hFFF, 1'b1, 1'b0);
    vecs[3]  = mk(2'b10, 8'd2, 2, 12'hFFF, 12'h002, 12'h000, 12'h000, 12'h001, 1'b1, 1'b0);
    vecs[4]  = mk(2'b10, 8'd2, 2, 12'h100, 12'h200, 12'h000, 12'h000, 12'h300, 1'b0, 1'b0);
    vecs[5]  = mk(2'b11, 8'd2, 2, 12'hFFF, 12'h002, 12'h000, 12'h000, 12'h001, 1'b1, 1'b0);
    vecs[6]  = mk(2'b00, 8'd0, 1, 12'h123, 12'h000, 12'h000, 12'h000, 12'h123, 1'b0, 1'b0);
    vecs[7]  = mk(2'b01, 8'd4, 4, 12'h800, 12'hFFF, 12'h001, 12'h7FF, 12'h000, 1'b1, 1'b0);
    vecs[8]  = mk(2'b00, 8'd3, 3, 12'h7F0, 12'h020, 12'h001, 12'h000, 12'h811, 1'b0, 1'b1);
    vecs[9]  = mk(2'b01, 8'd1, 1, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'hFFF, 1'b0, 1'b0);
    vecs[10] = mk(2'b00, 8'd4, 4, 12'h001, 12'h002, 12'h003, 12'h004, 12'h00A, 1'b0, 1'b0);

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; len = 8'd1; din = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_frame(vecs[i]);

    // Backpressure: result held stable for 5 cycles, input not consumed
    out_ready = 1'b0;
    q.push_back('{d: 12'h300, o: 1'b0});
    feed(vecs[4]);
    in_valid = 1'b1; din = 12'h555; mode = 2'b10; len = 8'd1;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_dout", 32'(dout), 32'h300);
      check("bp_ovf", 32'(ovf), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    q.push_back('{d: 12'h555, o: 1'b0});
    @(posedge clk);
    #1 check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_next_frame_valid", 32'(out_valid), 32'd1);
    wait_drain();

    // clr mid-frame with mode/len changes; the clr-cycle sample must be dropped
    mode = 2'b00; len = 8'd4;
    in_valid = 1'b1; din = 12'h001; wait_accept();
    din = 12'h002; wait_accept();
    mode = 2'b01; len = 8'd2; din = 12'h7FF; clr = 1'b1;
    @(negedge clk);
    check("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0; in_valid = 1'b0;
    check("clr_dout", 32'(dout), 32'd0);
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    run_frame(mk(2'b01, 8'd2, 2, 12'h001, 12'h002, 12'h000, 12'h000, 12'h003, 1'b0, 1'b0));

    // clr and out_ready together in HOLD: result dropped
    out_ready = 1'b1;
    feed(vecs[4]);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check("clr_hold_out_valid", 32'(out_valid), 32'd0);
    check("clr_hold_dout", 32'(dout), 32'd0);

    // Reset during HOLD
    out_ready = 1'b0;
    feed(mk(2'b00, 8'd1, 1, 12'h456, 12'h000, 12'h000, 12'h000, 12'h456, 1'b0, 1'b0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_out_valid", 32'(out_valid), 32'd0);
    check("rst_hold_dout", 32'(dout), 32'd0);
    check("rst_hold_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    run_frame(vecs[6]);
    run_frame(vecs[0]);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
